// File: rtl/serial_pkg.sv
// Shared definitions for the serial word link (transmitter and receiver).
// Contents:
//   DEFAULT_WIDTH - default word length shared by both ends of the link
//   ST_IDLE/RECV  - receiver FSM state encoding (1 bit)
//   cnt_width()   - width of a counter that spans 0..width-1
package serial_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [0:0] rx_state_t;

    localparam rx_state_t ST_IDLE = 1'b0;
    localparam rx_state_t ST_RECV = 1'b1;

    // Bits needed to count 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_word_hold.sv
// One-entry holding register with valid/ready handshake and sticky overflow.
// Ports:
//   clk, resetn    - clock (rising edge), asynchronous active-low reset
//   clear          - synchronous clear, highest priority
//   word/word_done - completed word from the assembler and its strobe
//   data_ready     - consumer takes data_out this cycle when data_valid=1
//   data_out       - held word (keeps its stale value after being taken)
//   data_valid     - holding register is full
//   overflow       - sticky: a completed word arrived while full and not taken
module serial_word_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic [WIDTH-1:0] word,
    input  logic             word_done,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overflow
);

    // Holding register, handshake and overflow flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out   <= {WIDTH{1'b0}};
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (clear) begin
            data_out   <= {WIDTH{1'b0}};
            data_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (word_done) begin
            // A word taken on this same edge frees the slot: load without a bubble.
            if (!data_valid || data_ready) begin
                data_out   <= word;
                data_valid <= 1'b1;
            end else begin
                overflow   <= 1'b1;
            end
        end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= data_valid;
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver. Reassembles WIDTH-bit words from a bit
// stream (no framing; boundaries counted from reset/clear) and hands them to
// a one-entry holding register.
// Ports:
//   clk, resetn          - clock (rising edge), asynchronous active-low reset
//   clear                - synchronous clear of everything, highest priority
//   ser_in, ser_valid    - serial bit and its sample strobe (no back-pressure)
//   data_out, data_valid - completed word and holding-register-full flag
//   data_ready           - consumer accept
//   busy                 - a partial word is in progress
//   bit_count            - bits collected in the current word (0..WIDTH-1)
//   overflow             - sticky dropped-word flag
module serial_word_rx
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1,
    localparam int CNT_W    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_count,
    output logic             overflow
);

    rx_state_t        state_r;
    rx_state_t        state_next_s;
    logic [CNT_W-1:0] bit_count_r;
    logic [CNT_W-1:0] count_next_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] shifted_s;
    logic             word_done_s;

    // Shift direction picks where the first received bit ends up.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign shifted_s = {ser_in, sreg_r[WIDTH-1:1]};
        end else begin : g_msb_first
            assign shifted_s = {sreg_r[WIDTH-2:0], ser_in};
        end
    endgenerate

    // Next-state, next-count and word-completion decode.
    always_comb begin
        state_next_s = state_r;
        count_next_s = bit_count_r;
        word_done_s  = 1'b0;
        if (ser_valid) begin
            case (state_r)
                ST_IDLE: begin
                    state_next_s = ST_RECV;
                    count_next_s = CNT_W'(1);
                end
                ST_RECV: begin
                    if (bit_count_r == CNT_W'(WIDTH - 1)) begin
                        state_next_s = ST_IDLE;
                        count_next_s = {CNT_W{1'b0}};
                        word_done_s  = 1'b1;
                    end else begin
                        count_next_s = bit_count_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    count_next_s = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_next_s = state_r;
            count_next_s = bit_count_r;
        end
    end

    // FSM state, bit counter and assembly shift register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            bit_count_r <= {CNT_W{1'b0}};
            sreg_r      <= {WIDTH{1'b0}};
        end else if (clear) begin
            state_r     <= ST_IDLE;
            bit_count_r <= {CNT_W{1'b0}};
            sreg_r      <= {WIDTH{1'b0}};
        end else begin
            state_r     <= state_next_s;
            bit_count_r <= count_next_s;
            if (ser_valid) begin
                sreg_r <= shifted_s;
            end else begin
                sreg_r <= sreg_r;
            end
        end
    end

    assign bit_count = bit_count_r;
    assign busy      = (bit_count_r != {CNT_W{1'b0}});

    // The completed word includes the bit sampled on the completion edge.
    serial_word_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .word       (shifted_s),
        .word_done  (word_done_s),
        .data_ready (data_ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overflow   (overflow)
    );

endmodule
